cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor for the factorial datapath.
//  Splits WIDTH into 4-bit lookahead groups (g=a&b, p=a|b, ripple-free carries inside each group).
//  Registers the group carry between pipeline stages so wide multiplies/accumulates close timing.
//  Uses a valid/ready stream on both sides; a single global stall freezes the whole pipe.
// PARAMETERS
//  WIDTH    32  operand/sum width; multiple of 4, min 4
//  GRP_PER_STG  2  4-bit lookahead groups resolved per pipeline stage, >=1
//  (derived) NGRP=WIDTH/4, NSTG=ceil(NGRP/GRP_PER_STG) = latency in cycles
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      a/b/ci/sub valid this cycle
//  in_ready   out  1      pipe accepts input this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  ci         in   1      carry in (add mode only)
//  sub        in   1      1: a-b (b inverted, carry in forced 1, ci ignored)
//  out_valid  out  1      sum/co/ovf valid
//  out_ready  in   1      consumer accepts output
//  sum        out  WIDTH  result mod 2^WIDTH
//  co         out  1      carry out of MSB group (sub: 1 = no borrow)
//  ovf        out  1      signed overflow: carry into MSB xor carry out of MSB
// BEHAVIOUR
//  - adv = !out_valid | out_ready; in_ready = adv (combinational from out_valid/out_ready).
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Stage k (0..NSTG-1) owns groups [k*GRP_PER_STG, min(NGRP,(k+1)*GRP_PER_STG)-1].
//  - Stage k: lookahead on its groups with the carry registered by stage k-1 (stage 0: cin).
//    Group carries per 4-bit: c1=g0|p0c, c2=g1|p1g0|p1p0c, c3.., co=g3|p3g2|p3p2g1|p3p2p1g0|p3..p0c.
//    Within a stage, group carries chain combinationally group to group.
//  - Operands for later stages are skewed: upper operand bits travel with the token; sum bits of
//    earlier stages are carried forward; one valid bit per stage.
//  - cin = sub ? 1 : ci; b_eff = sub ? ~b : b, applied at stage-0 input.
//  - When adv=1 every stage register shifts by one and stage 0 loads the input (valid = in_valid).
//    When adv=0 every register holds, including the valid bits; no bubble squeezing.
//  - Latency: sum appears NSTG cycles after the accept when there is no stall. Throughput is
//    1 per cycle.
//  - Reset (any cycle, including mid-operation): all valid bits 0; sum=0, co=0, ovf=0;
//    in-flight tokens are discarded. in_ready=1 in the cycle after reset.
//  - Outputs hold stable while out_valid & !out_ready.
//  - Data registers may be held without reset; outputs must read 0 while out_valid=0 after reset.
//  - ovf: carry into bit WIDTH-1 xor co, captured in the final stage.
//  - Edge cases: WIDTH=4 -> NSTG=1. GRP_PER_STG >= NGRP -> single stage. Partial last stage is legal.
// TESTING (WIDTH=16, GRP_PER_STG=1 -> NSTG=4 unless noted)
//  1 a=16'hFFFF,b=16'h0001,ci=0,sub=0, out_ready=1 -> 4 cyc later sum=16'h0000,co=1,ovf=0.
//  2 a=16'h7FFF,b=16'h0001 add -> sum=16'h8000,co=0,ovf=1; a=16'h0005,b=16'h0007,sub=1 ->
//    sum=16'hFFFE,co=0,ovf=0.
//  3 Back-to-back stream of 8 random pairs with out_ready=1 -> 8 outputs on consecutive cycles,
//    in order, matching a+b+ci.
//  4 Hold out_ready=0 for 3 cycles with a full pipe -> in_ready=0, sum/co/ovf stable.
//    Release -> no loss, no duplication.
//  5 Assert reset with 3 tokens in flight -> next cycle out_valid=0, sum=0, in_ready=1;
//    later tokens unaffected.
//  6 Sweep WIDTH=4/GRP_PER_STG=1 and WIDTH=32/GRP_PER_STG=3 (NSTG=3) -> latency equals NSTG;
//    exhaustive check of 4-bit add/sub.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// Each stage resolves GRP_PER_STG groups and registers the carry into the next stage.
module cla_pipe_adder #(
   parameter int WIDTH       = 32,
   parameter int GRP_PER_STG = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   localparam int NGRP = WIDTH / 4;
   localparam int NSTG = (NGRP + GRP_PER_STG - 1) / GRP_PER_STG;
   localparam int NOPS = (NSTG > 1) ? NSTG - 1 : 1;

   // c3 is the carry into the top bit of the group, needed for signed overflow.
   typedef struct packed {
      logic [3:0] s;
      logic       c3;
      logic       co;
   } grp_t;

   function automatic grp_t cla4(input logic [3:0] x, input logic [3:0] y, input logic c);
      logic [3:0] g;
      logic [3:0] p;
      logic [3:0] cin;
      grp_t       r;
      g      = x & y;
      p      = x | y;
      cin[0] = c;
      cin[1] = g[0] | (p[0] & c);
      cin[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      cin[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      r.co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c);
      r.s    = x ^ y ^ cin;
      r.c3   = cin[3];
      return r;
   endfunction

   logic [NSTG-1:0]  valid_q, valid_d;
   logic [NSTG-1:0]  carry_q, carry_d;
   logic [NSTG-1:0]  ovf_q, ovf_d;
   logic [WIDTH-1:0] sum_q  [NSTG];
   logic [WIDTH-1:0] sum_d  [NSTG];
   logic [WIDTH-1:0] op_a_q [NOPS];
   logic [WIDTH-1:0] op_a_d [NOPS];
   logic [WIDTH-1:0] op_b_q [NOPS];
   logic [WIDTH-1:0] op_b_d [NOPS];
   logic             adv;

   assign adv      = !valid_q[NSTG-1] | out_ready;
   assign in_ready = adv;

   always_comb begin
      logic [WIDTH-1:0] s_a;
      logic [WIDTH-1:0] s_b;
      logic [WIDTH-1:0] s_sum;
      logic             s_v;
      logic             s_ovf;
      logic             c;
      grp_t             r;
      int               km1;
      int               kk;
      valid_d = valid_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      sum_d   = sum_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      s_a     = '0;
      s_b     = '0;
      s_sum   = '0;
      s_v     = 1'b0;
      s_ovf   = 1'b0;
      c       = 1'b0;
      r       = '0;
      km1     = 0;
      kk      = 0;
      // Whole pipe shifts together; a stall holds everything, valid bits included.
      if (adv) begin
         for (int k = 0; k < NSTG; k++) begin
            km1 = (k > 0) ? k - 1 : 0;
            kk  = (k < NOPS) ? k : 0;
            if (k == 0) begin
               s_v   = in_valid;
               s_a   = a;
               s_b   = sub ? ~b : b;
               c     = sub | ci;
               s_sum = '0;
               s_ovf = 1'b0;
            end else begin
               s_v   = valid_q[km1];
               s_a   = op_a_q[km1];
               s_b   = op_b_q[km1];
               c     = carry_q[km1];
               s_sum = sum_q[km1];
               s_ovf = ovf_q[km1];
            end
            for (int g = 0; g < NGRP; g++) begin
               if (g / GRP_PER_STG == k) begin
                  r = cla4(s_a[4*g +: 4], s_b[4*g +: 4], c);
                  s_sum[4*g +: 4] = r.s;
                  c = r.co;
                  if (g == NGRP - 1) begin
                     s_ovf = r.c3 ^ r.co;
                  end
               end
            end
            valid_d[k] = s_v;
            carry_d[k] = c;
            ovf_d[k]   = s_ovf;
            sum_d[k]   = s_sum;
            if (k < NSTG - 1) begin
               op_a_d[kk] = s_a;
               op_b_d[kk] = s_b;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Data registers need no reset; the outputs are masked by the final valid bit.
   always_ff @(posedge clk) begin
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
   end

   assign out_valid = valid_q[NSTG-1];
   assign sum       = out_valid ? sum_q[NSTG-1] : '0;
   assign co        = out_valid & carry_q[NSTG-1];
   assign ovf       = out_valid & ovf_q[NSTG-1];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: 16-bit/4-stage main instance plus 4-bit and
// 32-bit/3-stage instances, checked against plain integer arithmetic.
module tb_cla_pipe_adder;

   localparam int W    = 16;
   localparam int NSTG = 4;

   typedef struct {
      logic [31:0] sum;
      logic        co;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1;
   logic          in_valid = 1'b0, in_ready, ci = 1'b0, sub = 1'b0;
   logic [W-1:0]  a = '0, b = '0, sum;
   logic          out_valid, out_ready = 1'b1, co, ovf;

   logic          v4 = 1'b0, rdy4, ci4 = 1'b0, sub4 = 1'b0, ov4, co4, ovf4;
   logic [3:0]    a4 = '0, b4 = '0, sum4;
   logic          v32 = 1'b0, rdy32, ci32 = 1'b0, sub32 = 1'b0, ov32, co32, ovf32;
   logic [31:0]   a32 = '0, b32 = '0, sum32;

   exp_t q16[$];
   exp_t q4[$];
   exp_t q32[$];
   int   errors = 0;
   int   checks = 0;
   bit   ordyCfg = 1'b1;
   bit   randReady = 1'b0;

   cla_pipe_adder #(.WIDTH(W), .GRP_PER_STG(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .co(co), .ovf(ovf));

   cla_pipe_adder #(.WIDTH(4), .GRP_PER_STG(1)) dut4 (
      .clk(clk), .reset(reset), .in_valid(v4), .in_ready(rdy4),
      .a(a4), .b(b4), .ci(ci4), .sub(sub4), .out_valid(ov4), .out_ready(1'b1),
      .sum(sum4), .co(co4), .ovf(ovf4));

   cla_pipe_adder #(.WIDTH(32), .GRP_PER_STG(3)) dut32 (
      .clk(clk), .reset(reset), .in_valid(v32), .in_ready(rdy32),
      .a(a32), .b(b32), .ci(ci32), .sub(sub32), .out_valid(ov32), .out_ready(1'b1),
      .sum(sum32), .co(co32), .ovf(ovf32));

   // Reference: (w+1)-bit integer add of a, effective b and carry-in; overflow from sign rules.
   function automatic exp_t model(int w, logic [31:0] x, logic [31:0] y, logic c, logic s);
      logic [63:0] mask, xa, yb, t;
      exp_t        r;
      mask  = (64'd1 << w) - 64'd1;
      xa    = {32'd0, x} & mask;
      yb    = {32'd0, (s ? ~y : y)} & mask;
      t     = xa + yb + {63'd0, (s ? 1'b1 : c)};
      r.sum = t[31:0] & mask[31:0];
      r.co  = t[w];
      r.ovf = (xa[w-1] == yb[w-1]) && (t[w-1] != xa[w-1]);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Main monitor: pops on every output transfer and checks outputs hold while stalled.
   initial begin : mon16
      logic [W-1:0] prevSum;
      logic         prevCo, prevOvf;
      bit           prevStall;
      exp_t         e;
      prevStall = 1'b0;
      prevSum = '0; prevCo = 1'b0; prevOvf = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prevStall = 1'b0;
         end else begin
            if (prevStall) begin
               checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
               checkOutput("hold_sum", {16'd0, sum}, {16'd0, prevSum});
               checkOutput("hold_flags", {30'd0, co, ovf}, {30'd0, prevCo, prevOvf});
            end
            if (out_valid && out_ready) begin
               if (q16.size() == 0) begin
                  checkOutput("unexpected_out16", 32'd1, 32'd0);
               end else begin
                  e = q16.pop_front();
                  checkOutput("sum16", {16'd0, sum}, e.sum);
                  checkOutput("co16", {31'd0, co}, {31'd0, e.co});
                  checkOutput("ovf16", {31'd0, ovf}, {31'd0, e.ovf});
               end
            end
            prevStall = out_valid && !out_ready;
            prevSum = sum; prevCo = co; prevOvf = ovf;
         end
      end
   end

   initial begin : mon4
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && ov4) begin
            if (q4.size() == 0) begin
               checkOutput("unexpected_out4", 32'd1, 32'd0);
            end else begin
               e = q4.pop_front();
               checkOutput("sum4", {28'd0, sum4}, e.sum);
               checkOutput("flags4", {30'd0, co4, ovf4}, {30'd0, e.co, e.ovf});
            end
         end
      end
   end

   initial begin : mon32
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && ov32) begin
            if (q32.size() == 0) begin
               checkOutput("unexpected_out32", 32'd1, 32'd0);
            end else begin
               e = q32.pop_front();
               checkOutput("sum32", sum32, e.sum);
               checkOutput("flags32", {30'd0, co32, ovf32}, {30'd0, e.co, e.ovf});
            end
         end
      end
   end

   // Drive one token into the main DUT, retrying until in_ready is seen before the edge.
   task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic c, input logic s);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done) begin
         @(posedge clk); #1;
         in_valid = 1'b1; a = x; b = y; ci = c; sub = s;
         out_ready = randReady ? 1'($urandom_range(0, 1)) : ordyCfg;
         @(negedge clk);
         if (in_ready) begin
            q16.push_back(model(W, {16'd0, x}, {16'd0, y}, c, s));
            done = 1'b1;
         end else if (++n > 50) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            done = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_valid = 1'b0; v4 = 1'b0; v32 = 1'b0;
         out_ready = randReady ? 1'($urandom_range(0, 1)) : ordyCfg;
         @(negedge clk);
      end
   endtask

   task automatic doReset();
      @(posedge clk); #1;
      reset = 1'b1; in_valid = 1'b0; v4 = 1'b0; v32 = 1'b0;
      q16.delete(); q4.delete(); q32.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_out_valid", {29'd0, out_valid, ov4, ov32}, 32'd0);
      checkOutput("rst_sum", {16'd0, sum}, 32'd0);
      checkOutput("rst_flags", {30'd0, co, ovf}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic drive4(input logic [3:0] x, input logic [3:0] y, input logic c, input logic s);
      @(posedge clk); #1;
      in_valid = 1'b0; v32 = 1'b0;
      v4 = 1'b1; a4 = x; b4 = y; ci4 = c; sub4 = s;
      @(negedge clk);
      checkOutput("in_ready4", {31'd0, rdy4}, 32'd1);
      q4.push_back(model(4, {28'd0, x}, {28'd0, y}, c, s));
   endtask

   task automatic drive32(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
      @(posedge clk); #1;
      in_valid = 1'b0; v4 = 1'b0;
      v32 = 1'b1; a32 = x; b32 = y; ci32 = c; sub32 = s;
      @(negedge clk);
      if (rdy32) q32.push_back(model(32, x, y, c, s));
   endtask

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      int lat;
      idle(2);
      doReset();

      // Carry out of every group: FFFF + 1, with latency measured.
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         idle(1);
         if (out_valid) lat = i;
      end
      checkOutput("latency16", lat, NSTG);
      checkOutput("t1_sum", {16'd0, sum}, 32'd0);
      checkOutput("t1_flags", {30'd0, co, ovf}, 32'b10);
      idle(2);

      applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1);
      applyStimulus(16'h8000, 16'h8000, 1'b1, 1'b0);
      applyStimulus(16'h0000, 16'h0001, 1'b1, 1'b1);
      idle(NSTG + 2);

      for (int i = 0; i < 8; i++)
         applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      idle(NSTG + 2);
      checkOutput("stream_drained", q16.size(), 0);

      // Fill the pipe against a blocked consumer, then release it.
      ordyCfg = 1'b0;
      for (int i = 0; i < NSTG; i++)
         applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      for (int i = 0; i < 3; i++) begin
         idle(1);
         checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      checkOutput("stall_queue", q16.size(), NSTG);
      ordyCfg = 1'b1;
      idle(NSTG + 2);
      checkOutput("stall_drained", q16.size(), 0);

      for (int i = 0; i < 3; i++)
         applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      doReset();
      for (int i = 0; i < 4; i++)
         applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      idle(NSTG + 2);
      checkOutput("post_reset_drained", q16.size(), 0);

      randReady = 1'b1;
      for (int i = 0; i < 200; i++) begin
         applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      randReady = 1'b0;
      idle(NSTG + 4);
      checkOutput("random_drained", q16.size(), 0);

      drive4(4'hF, 4'h1, 1'b0, 1'b0);
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         idle(1);
         if (ov4) lat = i;
      end
      checkOutput("latency4", lat, 1);
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            for (int m = 0; m < 4; m++)
               drive4(4'(x), 4'(y), m[0], m[1]);
      idle(3);
      checkOutput("exhaustive4_drained", q4.size(), 0);

      drive32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         idle(1);
         if (ov32) lat = i;
      end
      checkOutput("latency32", lat, 3);
      drive32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      drive32(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
      for (int i = 0; i < 100; i++)
         drive32($urandom, $urandom, 1'($urandom), 1'($urandom));
      idle(5);
      checkOutput("rand32_drained", q32.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
